// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (signed overflow output).
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } serial_adder_state_t;

  // Bit counter only has to reach WIDTH-1, and is kept at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between operand capture, the serial adder and the display path.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf signal.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/full_adder_struc.sv
// Existing 1-bit full adder cell, gate-level form.
// Optional feature macro: none (SERIAL_ADDER_OVF_EN does not affect this cell).
module full_adder_struc (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = cin & ab_x;
  assign sum  = ab_x ^ cin;
  assign cout = ab_a | cx_a;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full adder cell, registered carry.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned       CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0]   LastCnt = CntW'(WIDTH - 1);

  serial_adder_state_t state_q, state_d;
  logic [WIDTH-1:0]    a_sh_q, a_sh_d;
  logic [WIDTH-1:0]    b_sh_q, b_sh_d;
  logic [WIDTH-1:0]    sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                done_q, done_d;
  logic                load;
  logic                fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  full_adder_struc u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    load     = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) load = 1'b1;
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q still holds the carry into the MSB on the last shift.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      DONE: begin
        if (bus.start) load = 1'b1;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_sh_d   = bus.a;
      b_sh_d   = bus.b;
      carry_d  = bus.cin;
      sum_sh_d = '0;
      cnt_d    = '0;
      state_d  = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
